// File: rtl/instr_encoder.sv
// instr_encoder
// Packs RISC-V instruction fields and a decoder-form 32-bit immediate into a
// 32-bit instruction word. This is the inverse of the CPU immediate decoder.
// It flags any immediate that the selected format cannot represent.
// The block is a two-stage pipeline with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst             system clock; asynchronous active-high reset
//   in_valid / in_ready  request handshake
//   in_type              format code (I/S/B/U/J below; any other code = R)
//   in_opcode .. in_imm  instruction fields and immediate
//   out_valid/out_ready  result handshake
//   out_instr, out_err   encoded word; immediate-not-representable flag
//   err_count            saturating count of errored words delivered
//   busy                 either pipeline stage holds a request
module instr_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_type,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    // Format codes shared with the CPU decoder header.
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] S_TYPE = 3'd2;
    localparam logic [2:0] B_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE = 3'd4;
    localparam logic [2:0] J_TYPE = 3'd5;

    logic        ready_en;
    logic        s1_valid;
    logic [2:0]  s1_type;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;

    logic        s2_load;
    logic        in_fire;
    logic        out_fire;
    logic [31:0] enc_instr;
    logic        enc_err;

    assign s2_load  = !s2_valid || out_ready;
    // ready_en holds in_ready low for the first cycle out of reset.
    assign in_ready = ready_en && (!s1_valid || s2_load);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign busy      = s1_valid || s2_valid;

    // Sign-extension checks: all upper bits equal means the value fits.
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (s1_type)
            I_TYPE: begin
                enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                enc_err   = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            S_TYPE: begin
                enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:0], s1_opcode};
                enc_err   = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            B_TYPE: begin
                enc_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
                enc_err   = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
            end
            U_TYPE: begin
                enc_instr = {s1_imm[31:12], s1_rd, s1_opcode};
                enc_err   = |s1_imm[11:0];
            end
            J_TYPE: begin
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_rd, s1_opcode};
                enc_err   = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
            end
            default: begin
                enc_instr = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
                enc_err   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_type   <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_type   <= in_type;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= enc_instr;
                s2_err   <= enc_err;
            end
        end
    end

    // Counts on the output transfer only, so a stalled word counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (out_fire && s2_err && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam logic [2:0] I_T = 3'd1;
    localparam logic [2:0] S_T = 3'd2;
    localparam logic [2:0] B_T = 3'd3;
    localparam logic [2:0] U_T = 3'd4;
    localparam logic [2:0] J_T = 3'd5;
    localparam logic [2:0] R_T = 3'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;
    logic        busy;

    int total = 0;
    int bad = 0;

    instr_encoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference immediate decoder (standard RISC-V layouts).
    function automatic logic [31:0] dec_imm(input logic [2:0] t, input logic [31:0] i);
        case (t)
            I_T:     return {{20{i[31]}}, i[31:20]};
            S_T:     return {{20{i[31]}}, i[31:25], i[11:7]};
            B_T:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            U_T:     return {i[31:12], 12'b0};
            J_T:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic err_rule(input logic [2:0] t, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (t)
            I_T, S_T: return !(s >= -2048 && s <= 2047);
            B_T:      return !(s >= -4096 && s <= 4095 && imm[0] == 1'b0);
            J_T:      return !(s >= -1048576 && s <= 1048575 && imm[0] == 1'b0);
            U_T:      return imm[11:0] != 12'd0;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // One request through an empty pipeline, checking latency and result.
    task automatic do_word(input string tag, input logic [2:0] t, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] exp_instr, input logic exp_err, input int stall);
        bit ok;
        @(negedge clk);
        drive(t, op, rd, rs1, rs2, f3, f7, imm);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_i"}, out_instr, exp_instr);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] bp_instr [4];
    int acc, got, first_c, n, sent, rcv;
    bit do_acc, ok;
    exp_t cur, e;
    int mode, s;

    initial begin
        // Reset
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_early", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_after", 32'(in_ready), 32'd1);

        // Directed encodings; unused fields carry junk that must be ignored.
        do_word("addi", I_T, 7'h13, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF,
                32'hFFF10093, 1'b0, 0);
        do_word("sw",   S_T, 7'h23, 5'd31, 5'd2, 5'd5, 3'd2, 7'h7F, 32'h00000008,
                32'h00512423, 1'b0, 0);
        do_word("beq",  B_T, 7'h63, 5'd31, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFFFFFE,
                32'hFE208FE3, 1'b0, 0);
        do_word("jal",  J_T, 7'h6F, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000800,
                32'h001000EF, 1'b0, 0);
        do_word("lui",  U_T, 7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345000,
                32'h123452B7, 1'b0, 0);
        do_word("add",  R_T, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF,
                32'h405201B3, 1'b0, 0);
        chk("no_err_count", 32'(err_count), 32'd0);

        // Error cases; the U-type one is stalled and must count once.
        do_word("i_err", I_T, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h00000800,
                32'h80010093, 1'b1, 0);
        do_word("b_err", B_T, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003,
                32'h00208163, 1'b1, 0);
        do_word("u_err", U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001,
                32'h000002B7, 1'b1, 3);
        chk("err_count3", 32'(err_count), 32'd3);

        // Saturation: 300 errored words streamed back to back.
        @(negedge clk);
        out_ready = 1'b1;
        drive(U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001);
        in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 1000 && n < 300; c++) begin
            @(negedge clk);
            if (in_ready) n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("sat_accepted", 32'(n), 32'd300);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_count", 32'(err_count), 32'd255);
        chk("sat_idle", 32'(busy), 32'd0);

        // Backpressure: 4 requests with out_ready low.
        for (int k = 0; k < 4; k++) bp_instr[k] = ((k + 1) << 20) | 32'h00000093;
        @(negedge clk);
        out_ready = 1'b0;
        drive(I_T, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            #1;
            do_acc = in_ready;
            @(posedge clk); #1;
            if (do_acc) begin
                acc++;
                in_imm = 32'(acc + 1);
            end
            @(negedge clk);
        end
        #1;
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_head", out_instr, bp_instr[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("bp_full_hold", 32'(in_ready), 32'd0);
            chk("bp_head_hold", out_instr, bp_instr[0]);
        end
        out_ready = 1'b1;
        #1;
        got = 0;
        first_c = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            do_acc = in_valid && in_ready;
            if (out_valid) begin
                if (got == 0) first_c = c;
                chk("bp_order", out_instr, bp_instr[got]);
                chk("bp_gap", 32'(c - first_c), 32'(got));
                got++;
            end
            @(posedge clk); #1;
            if (do_acc) begin
                acc++;
                if (acc < 4) in_imm = 32'(acc + 1);
                else in_valid = 1'b0;
            end
            @(negedge clk); #1;
        end
        chk("bp_count", 32'(got), 32'd4);
        chk("bp_no_dup", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset with two requests in flight.
        @(negedge clk);
        out_ready = 1'b0;
        drive(I_T, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h00000800);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_word("post_rst", U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,
                32'h123452B7, 1'b0, 0);

        // Random round trip against the reference decoder.
        sent = 0;
        rcv = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 60000 && rcv < 10000; c++) begin
            if (!in_valid && sent < 10000) begin
                cur.t  = 3'($urandom_range(0, 7));
                cur.op = 7'($urandom);
                cur.f7 = 7'($urandom);
                mode = $urandom_range(0, 3);
                case (cur.t)
                    I_T, S_T: s = $urandom_range(0, 4095) - 2048;
                    B_T:      s = ($urandom_range(0, 4095) - 2048) * 2;
                    J_T:      s = ($urandom_range(0, 1048575) - 524288) * 2;
                    default:  s = int'($urandom & 32'hFFFFF000);
                endcase
                cur.imm = (mode == 0) ? $urandom : 32'(s);
                cur.err = err_rule(cur.t, cur.imm);
                drive(cur.t, cur.op, 5'($urandom), 5'($urandom), 5'($urandom),
                      3'($urandom), cur.f7, cur.imm);
                in_valid = 1'b1;
            end
            #1;
            do_acc = in_valid && in_ready;
            if (do_acc) sb.push_back(cur);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_extra_word", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_opcode", 32'(out_instr[6:0]), 32'(e.op));
                    chk("rnd_err", 32'(out_err), 32'(e.err));
                    if (e.t inside {I_T, S_T, B_T, U_T, J_T}) begin
                        if (!e.err) chk("rnd_roundtrip", dec_imm(e.t, out_instr), e.imm);
                    end else begin
                        chk("rnd_r_funct7", 32'(out_instr[31:25]), 32'(e.f7));
                    end
                end
                rcv++;
            end
            @(posedge clk); #1;
            if (do_acc) begin
                sent++;
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        chk("rnd_received", 32'(rcv), 32'd10000);
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
